id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV32I decode stage sitting directly upstream of the register file.
- Takes fetched instructions over a valid/ready handshake and decodes fields and immediates.
- Drives the register file's combinational read addresses, bypasses same-cycle writeback data, and tracks pending destination writes in a scoreboard to stall on RAW/WAW hazards.
- Holds the result in a single ID/EX pipeline register with valid/ready handshake toward execute.

Parameters:
- XLEN, 32, datapath and PC width
- REG_AW, 5, register address width (32 architectural registers)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch holds a valid instruction
- if_ready  out  1  ID accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- src1_addr  out  REG_AW  regfile read port 1 address (= if_instr[19:15])
- src2_addr  out  REG_AW  regfile read port 2 address (= if_instr[24:20])
- src1_data  in  XLEN  regfile read data 1 (combinational)
- src2_data  in  XLEN  regfile read data 2 (combinational)
- wb_valid  in  1  writeback retiring a register write this cycle
- wb_addr  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  kill the instruction held in the ID/EX register
- ex_valid  out  1  ID/EX register valid
- ex_ready  in  1  execute accepts
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  decoded operands
- ex_rd  out  REG_AW  destination
- ex_rd_we  out  1  destination write enable
- ex_opcode  out  7;  ex_funct3  out  3;  ex_funct7  out  7  raw fields
- ex_illegal  out  1  undecodable instruction

Behaviour:
Reset:
- rst_n low: ex_valid=0, all ex_* = 0, scoreboard all 0, if_ready=0.
- Reset mid-stall or mid-flush discards everything; no state survives.

Decode:
- Combinational from if_instr.
- uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- uses_rs2: BRANCH, STORE, OP.
- rd_we: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and rd != 0.
- MISC-MEM and SYSTEM: legal, rd_we=0, no source use.
- Any other opcode, or instr[1:0] != 2'b11: illegal=1, rd_we=0, no source use, no hazard check.

Immediates:
- Types I/S/B/U/J per RV32I, sign-extended to XLEN from instr[31].
- B and J bit0 = 0.
- R-type and illegal: imm=0.

Operands:
- Bypass per source: if wb_valid && wb_addr == rs && rs != 0, use wb_data; else use the regfile data.
- rs == 0 always yields 0, regardless of regfile contents.

Scoreboard:
- busy[31:1] bits; busy[0] is hard-wired 0.
- Hazard: (uses_rs1 && busy[rs1] && !bypass1) || (uses_rs2 && busy[rs2] && !bypass2) || (rd_we && busy[rd] && !(wb_valid && wb_addr == rd)).

Handshake:
- if_ready = rst_n && !flush && !hazard && (!ex_valid || ex_ready).
- Accept (if_valid && if_ready): the ID/EX register loads on the next edge, ex_valid=1, latency 1 cycle. If rd_we, set busy[rd].
- If ex_valid && ex_ready and there is no accept: ex_valid <= 0.
- ex_valid && !ex_ready: all ex_* held stable.

Scoreboard updates:
- wb_valid clears busy[wb_addr] (x0 ignored).
- Set and clear on the same register in the same cycle: set wins.

Flush:
- Next edge: ex_valid <= 0, no accept that cycle.
- If the killed instruction had ex_rd_we, clear busy[ex_rd].
- Instructions already past EX are never flushed and clear their bits via writeback.

Decomposition:
- Package rv32i_pkg:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM)
  - imm_type enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
  - XLEN/REG_AW defaults
- One combinational sub-module, id_imm_gen (instr, imm_type -> imm).
- Scoreboard and pipeline register stay in id_stage.

Test Plan:
- Reset, then if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_imm=0x00000005, ex_rd=1, ex_rd_we=1, ex_rs1_val=0; busy[1]=1.
- Follow with 0x00108133 (add x2,x1,x1) -> if_ready=0 each cycle until wb_valid=1, wb_addr=1, wb_data=5; accepted that cycle; next cycle ex_rs1_val=ex_rs2_val=5, ex_rd=2.
- 0xFE000EE3 (beq x0,x0,-4) -> ex_imm=0xFFFFFFFC, ex_rd_we=0, ex_opcode=0x63, no busy bits set.
- addi x1 held in ID/EX with ex_ready=0 for 3 cycles -> ex_* stable, if_ready=0. Then flush=1 -> ex_valid=0, busy[1]=0; next add x2,x1,x1 accepted immediately with regfile data.
- 0x00000000 -> ex_illegal=1, ex_rd_we=0. Then 0x00100013 (addi x0,x0,1) -> ex_rd_we=0; a following x0 reader never stalls and reads 0 even with the regfile driving 0xDEADBEEF.
- Assert rst_n low during a hazard stall -> ex_valid=0 and busy cleared immediately; after release, the stalled add is accepted without waiting for writeback.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, immediate formats and default widths
package rv32i_pkg;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_REG_AW = 5;

    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

endpackage

// File: rtl/id_imm_gen.sv
// rtl/id_imm_gen.sv - RV32I immediate extraction, sign-extended from instr[31]
module id_imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = XLEN'($signed(instr[31:20]));
            IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with writeback bypass, hazard scoreboard and ID/EX register
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic [REG_AW-1:0] src1_addr,
    output logic [REG_AW-1:0] src2_addr,
    input  logic [XLEN-1:0]   src1_data,
    input  logic [XLEN-1:0]   src2_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_illegal
);

    localparam int NREG = 1 << REG_AW;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              uses_rs1, uses_rs2, writes_rd, illegal, rd_we;
    imm_type_e         imm_type;
    logic [XLEN-1:0]   imm, rs1_val, rs2_val;
    logic              bypass1, bypass2, wb_hits_rd, hazard, accept;
    logic [NREG-1:0]   busy, busy_next;

    assign opcode    = if_instr[6:0];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign rd        = if_instr[11:7];
    assign src1_addr = rs1;
    assign src2_addr = rs2;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        imm_type  = IMM_NONE;
        if (if_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                LUI, AUIPC: begin writes_rd = 1'b1; imm_type = IMM_U; end
                JAL:        begin writes_rd = 1'b1; imm_type = IMM_J; end
                JALR, LOAD, OP_IMM: begin
                    writes_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I;
                end
                BRANCH:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_B; end
                STORE:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_S; end
                OP:         begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                MISC_MEM, SYSTEM: imm_type = IMM_I;
                default:    illegal = 1'b1;
            endcase
        end
    end

    assign rd_we = writes_rd && (rd != '0);

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (if_instr[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // x0 reads as zero and is never bypassed, so it can never create a hazard
    assign bypass1    = wb_valid && (wb_addr == rs1) && (rs1 != '0);
    assign bypass2    = wb_valid && (wb_addr == rs2) && (rs2 != '0);
    assign wb_hits_rd = wb_valid && (wb_addr == rd);
    assign rs1_val    = (rs1 == '0) ? '0 : (bypass1 ? wb_data : src1_data);
    assign rs2_val    = (rs2 == '0) ? '0 : (bypass2 ? wb_data : src2_data);

    assign hazard = (uses_rs1 && busy[rs1] && !bypass1)
                 || (uses_rs2 && busy[rs2] && !bypass2)
                 || (rd_we && busy[rd] && !wb_hits_rd);

    assign if_ready = rst_n && !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // Clears are applied before the set so a same-cycle set on the same register wins
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_addr] = 1'b0;
        if (flush && ex_valid && ex_rd_we)
            busy_next[ex_rd] = 1'b0;
        if (accept && rd_we)
            busy_next[rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_opcode  <= '0;
            ex_funct3  <= '0;
            ex_funct7  <= '0;
            ex_illegal <= 1'b0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (accept) begin
                ex_valid   <= 1'b1;
                ex_pc      <= if_pc;
                ex_rs1_val <= rs1_val;
                ex_rs2_val <= rs2_val;
                ex_imm     <= imm;
                ex_rd      <= rd;
                ex_rd_we   <= rd_we;
                ex_opcode  <= opcode;
                ex_funct3  <= if_instr[14:12];
                ex_funct7  <= if_instr[31:25];
                ex_illegal <= illegal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  src1_addr, src2_addr;
    logic [31:0] src1_data, src2_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_illegal;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADD_X2  = 32'h00108133;
    localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;
    localparam logic [31:0] ADDI_X0 = 32'h00100013;
    localparam logic [31:0] ADD_X3  = 32'h000001B3;

    id_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .src1_data  (src1_data),
        .src2_data  (src2_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_rd      (ex_rd),
        .ex_rd_we   (ex_rd_we),
        .ex_opcode  (ex_opcode),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_illegal (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        src1_data = 32'h0; src2_data = 32'h0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic retire(input logic [4:0] r);
        if_valid = 1'b0; wb_valid = 1'b1; wb_addr = r; wb_data = 32'h0;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid got %0h exp 0", ex_valid); end
        vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL reset_if_ready got %0h exp 0", if_ready); end
        vectors++; if ({ex_pc, ex_rs1_val, ex_rs2_val, ex_imm} !== 128'h0) begin miscompares++; $display("FAIL reset_ex_data got %0h exp 0", {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm}); end
        vectors++; if ({ex_rd, ex_rd_we, ex_opcode, ex_funct3, ex_funct7, ex_illegal} !== 24'h0) begin miscompares++; $display("FAIL reset_ex_fields got %0h exp 0", {ex_rd, ex_rd_we, ex_opcode, ex_funct3, ex_funct7, ex_illegal}); end
        vectors++; if (dut.busy !== 32'h0) begin miscompares++; $display("FAIL reset_busy got %0h exp 0", dut.busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = ADDI_X1; if_pc = 32'h100; src1_data = 32'h1234; ex_ready = 1'b1;
        #1;
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL addi_if_ready got %0h exp 1", if_ready); end
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL addi_ex_valid got %0h exp 1", ex_valid); end
        vectors++; if (ex_imm !== 32'h5) begin miscompares++; $display("FAIL addi_imm got %0h exp 5", ex_imm); end
        vectors++; if (ex_rd !== 5'd1 || ex_rd_we !== 1'b1) begin miscompares++; $display("FAIL addi_rd got %0h/%0h exp 1/1", ex_rd, ex_rd_we); end
        vectors++; if (ex_rs1_val !== 32'h0) begin miscompares++; $display("FAIL addi_rs1_x0 got %0h exp 0", ex_rs1_val); end
        vectors++; if (ex_pc !== 32'h100) begin miscompares++; $display("FAIL addi_pc got %0h exp 100", ex_pc); end
        vectors++; if (dut.busy[1] !== 1'b1) begin miscompares++; $display("FAIL addi_busy1 got %0h exp 1", dut.busy[1]); end
    endtask

    task automatic test_raw_stall();
        if_instr = ADD_X2; if_pc = 32'h104; src1_data = 32'h99; src2_data = 32'h98;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_%0d got %0h exp 0", i, if_ready); end
            tick();
        end
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h5;
        #1;
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL raw_bypass_ready got %0h exp 1", if_ready); end
        tick();
        wb_valid = 1'b0; if_valid = 1'b0;
        vectors++; if (ex_rs1_val !== 32'h5 || ex_rs2_val !== 32'h5) begin miscompares++; $display("FAIL raw_bypass_vals got %0h/%0h exp 5/5", ex_rs1_val, ex_rs2_val); end
        vectors++; if (ex_rd !== 5'd2 || ex_funct3 !== 3'd0 || ex_opcode !== 7'h33) begin miscompares++; $display("FAIL raw_add_fields got %0h/%0h/%0h exp 2/0/33", ex_rd, ex_funct3, ex_opcode); end
        vectors++; if (dut.busy !== 32'h4) begin miscompares++; $display("FAIL raw_busy got %0h exp 4", dut.busy); end
        retire(5'd2);
    endtask

    task automatic test_branch();
        if_valid = 1'b1; if_instr = BEQ_M4; if_pc = 32'h200; src1_data = 32'h7; src2_data = 32'h7;
        tick();
        if_valid = 1'b0;
        vectors++; if (ex_imm !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL beq_imm got %0h exp fffffffc", ex_imm); end
        vectors++; if (ex_rd_we !== 1'b0 || ex_opcode !== 7'h63 || ex_funct7 !== 7'h7F) begin miscompares++; $display("FAIL beq_fields got %0h/%0h/%0h exp 0/63/7f", ex_rd_we, ex_opcode, ex_funct7); end
        vectors++; if (dut.busy !== 32'h0) begin miscompares++; $display("FAIL beq_busy got %0h exp 0", dut.busy); end
        tick();
    endtask

    task automatic test_hold_flush();
        if_valid = 1'b1; if_instr = ADDI_X1; if_pc = 32'h300; ex_ready = 1'b0;
        tick();
        if_instr = BEQ_M4; if_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL hold_if_ready_%0d got %0h exp 0", i, if_ready); end
            tick();
            vectors++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_imm !== 32'h5 || ex_rd !== 5'd1) begin miscompares++; $display("FAIL hold_stable_%0d got %0h/%0h/%0h/%0h exp 1/300/5/1", i, ex_valid, ex_pc, ex_imm, ex_rd); end
        end
        flush = 1'b1;
        #1;
        vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL flush_if_ready got %0h exp 0", if_ready); end
        tick();
        flush = 1'b0;
        vectors++; if (ex_valid !== 1'b0 || dut.busy[1] !== 1'b0) begin miscompares++; $display("FAIL flush_kill got %0h/%0h exp 0/0", ex_valid, dut.busy[1]); end
        if_instr = ADD_X2; if_pc = 32'h308; src1_data = 32'h7; src2_data = 32'h9; ex_ready = 1'b1;
        #1;
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL flush_next_ready got %0h exp 1", if_ready); end
        tick();
        if_valid = 1'b0;
        vectors++; if (ex_valid !== 1'b1 || ex_rs1_val !== 32'h7 || ex_rs2_val !== 32'h9) begin miscompares++; $display("FAIL flush_next_vals got %0h/%0h/%0h exp 1/7/9", ex_valid, ex_rs1_val, ex_rs2_val); end
        retire(5'd2);
    endtask

    task automatic test_illegal_x0();
        if_valid = 1'b1; if_instr = 32'h0;
        tick();
        vectors++; if (ex_illegal !== 1'b1 || ex_rd_we !== 1'b0 || ex_imm !== 32'h0) begin miscompares++; $display("FAIL illegal got %0h/%0h/%0h exp 1/0/0", ex_illegal, ex_rd_we, ex_imm); end
        if_instr = ADDI_X0;
        tick();
        vectors++; if (ex_illegal !== 1'b0 || ex_rd_we !== 1'b0 || ex_imm !== 32'h1) begin miscompares++; $display("FAIL addi_x0 got %0h/%0h/%0h exp 0/0/1", ex_illegal, ex_rd_we, ex_imm); end
        vectors++; if (dut.busy !== 32'h0) begin miscompares++; $display("FAIL addi_x0_busy got %0h exp 0", dut.busy); end
        if_instr = ADD_X3; src1_data = 32'hDEADBEEF; src2_data = 32'hDEADBEEF;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
        #1;
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL x0_reader_ready got %0h exp 1", if_ready); end
        tick();
        if_valid = 1'b0; wb_valid = 1'b0;
        vectors++; if (ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h0 || ex_rd !== 5'd3) begin miscompares++; $display("FAIL x0_reader_vals got %0h/%0h/%0h exp 0/0/3", ex_rs1_val, ex_rs2_val, ex_rd); end
        retire(5'd3);
    endtask

    task automatic test_reset_during_stall();
        if_valid = 1'b1; if_instr = ADDI_X1; src1_data = 32'h0;
        tick();
        if_instr = ADD_X2; src1_data = 32'h11; src2_data = 32'h22;
        tick();
        #1;
        vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL rst_stall_ready got %0h exp 0", if_ready); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ex_valid !== 1'b0 || dut.busy !== 32'h0 || if_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall got %0h/%0h/%0h exp 0/0/0", ex_valid, dut.busy, if_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %0h exp 1", if_ready); end
        tick();
        if_valid = 1'b0;
        vectors++; if (ex_valid !== 1'b1 || ex_rs1_val !== 32'h11 || ex_rs2_val !== 32'h22 || ex_rd !== 5'd2) begin miscompares++; $display("FAIL rst_release_accept got %0h/%0h/%0h/%0h exp 1/11/22/2", ex_valid, ex_rs1_val, ex_rs2_val, ex_rd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_stall();
        test_branch();
        test_hold_flush();
        test_illegal_x0();
        test_reset_during_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
